// File: rtl/loc_pkg.sv
// Shared definitions for the source-location filter: coordinate width,
// default display geometry, FSM state encoding and the output clamp helper.
package loc_pkg;

   localparam int unsigned COORD_W       = 26;
   localparam int unsigned H_ACT_DEFAULT = 1280;
   localparam int unsigned V_ACT_DEFAULT = 720;

   typedef enum logic {
      EMPTY = 1'b0,
      TRACK = 1'b1
   } state_e;

   function automatic logic signed [COORD_W-1:0] clamp_coord(
      input logic signed [COORD_W-1:0] v,
      input logic signed [COORD_W-1:0] hi
   );
      if (v < 0) return '0;
      if (v > hi) return hi;
      return v;
   endfunction

endpackage

// File: rtl/loc_avg.sv
// One-axis moving average: circular sample buffer, running sum and a
// registered floor(sum / 2^AVG_LOG2).
module loc_avg
   import loc_pkg::*;
#(
   parameter int unsigned AVG_LOG2 = 3
) (
   input  logic                      clk_i,
   input  logic                      rst_n_i,
   input  logic                      prime_i,
   input  logic                      upd_i,
   input  logic signed [COORD_W-1:0] sample_i,
   output logic signed [COORD_W-1:0] avg_o
);

   localparam int unsigned DEPTH = 1 << AVG_LOG2;
   localparam int unsigned SUM_W = COORD_W + AVG_LOG2;

   logic signed [COORD_W-1:0] buf_q [DEPTH];
   logic signed [COORD_W-1:0] buf_d [DEPTH];
   logic        [AVG_LOG2-1:0] ptr_q, ptr_d;
   logic signed [SUM_W-1:0]   sum_q, sum_d;
   logic signed [SUM_W-1:0]   sample_ext;
   logic signed [COORD_W-1:0] avg_q, avg_d;

   assign sample_ext = SUM_W'(sample_i);

   always_comb begin
      buf_d = buf_q;
      ptr_d = ptr_q;
      sum_d = sum_q;
      if (prime_i) begin
         for (int unsigned i = 0; i < DEPTH; i++) buf_d[i] = sample_i;
         sum_d = sample_ext <<< AVG_LOG2;
      end else if (upd_i) begin
         buf_d[ptr_q] = sample_i;
         sum_d        = sum_q + sample_ext - SUM_W'(buf_q[ptr_q]);
         ptr_d        = ptr_q + 1'b1;
      end
   end

   // Arithmetic shift floors toward negative infinity for negative sums.
   assign avg_d = COORD_W'(sum_q >>> AVG_LOG2);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int unsigned i = 0; i < DEPTH; i++) buf_q[i] <= '0;
         ptr_q <= '0;
         sum_q <= '0;
         avg_q <= '0;
      end else begin
         buf_q <= buf_d;
         ptr_q <= ptr_d;
         sum_q <= sum_d;
         avg_q <= avg_d;
      end
   end

   assign avg_o = avg_q;

endmodule

// File: rtl/src_loc_filter.sv
// Source-location smoother: per-axis moving average, frame-timeout tracking
// and a vsync-aligned output latch. Define SRC_LOC_CLAMP_EN to clamp outputs.
module src_loc_filter
   import loc_pkg::*;
#(
   parameter int unsigned AVG_LOG2       = 3,
   parameter int unsigned H_ACT          = H_ACT_DEFAULT,
   parameter int unsigned V_ACT          = V_ACT_DEFAULT,
   parameter int unsigned TIMEOUT_FRAMES = 30
) (
   input  logic                      video_clk,
   input  logic                      rst_n,
   input  logic signed [COORD_W-1:0] loc_x_in,
   input  logic signed [COORD_W-1:0] loc_y_in,
   input  logic                      loc_valid,
   input  logic                      frame_vs,
   output logic signed [COORD_W-1:0] pix_x_out,
   output logic signed [COORD_W-1:0] pix_y_out,
   output logic                      ena
);

   localparam int unsigned      TMO_W   = $clog2(TIMEOUT_FRAMES + 1);
   localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_FRAMES);

   state_e                    state_q, state_d;
   logic [TMO_W-1:0]          tmo_q, tmo_d;
   logic                      vs_q, vs_rise;
   logic                      prime, upd;
   logic signed [COORD_W-1:0] avg_x, avg_y, lat_x, lat_y;
   logic signed [COORD_W-1:0] pix_x_q, pix_y_q;
   logic                      ena_q;

   assign vs_rise = frame_vs & ~vs_q;

   always_ff @(posedge video_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         tmo_q   <= '0;
         vs_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         tmo_q   <= tmo_d;
         vs_q    <= frame_vs;
      end
   end

   // A sample always takes precedence over a coincident timeout edge.
   always_comb begin
      state_d = state_q;
      tmo_d   = tmo_q;
      unique case (state_q)
         EMPTY: begin
            if (loc_valid) begin
               state_d = TRACK;
               tmo_d   = '0;
            end
         end
         TRACK: begin
            if (loc_valid) begin
               tmo_d = '0;
            end else if (vs_rise) begin
               if (tmo_q != TMO_MAX) tmo_d = tmo_q + 1'b1;
               if (tmo_d == TMO_MAX) state_d = EMPTY;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   always_comb begin
      prime = loc_valid && (state_q == EMPTY);
      upd   = loc_valid && (state_q == TRACK);
   end

   loc_avg #(.AVG_LOG2(AVG_LOG2)) u_avg_x (
      .clk_i    (video_clk),
      .rst_n_i  (rst_n),
      .prime_i  (prime),
      .upd_i    (upd),
      .sample_i (loc_x_in),
      .avg_o    (avg_x)
   );

   loc_avg #(.AVG_LOG2(AVG_LOG2)) u_avg_y (
      .clk_i    (video_clk),
      .rst_n_i  (rst_n),
      .prime_i  (prime),
      .upd_i    (upd),
      .sample_i (loc_y_in),
      .avg_o    (avg_y)
   );

`ifdef SRC_LOC_CLAMP_EN
   assign lat_x = clamp_coord(avg_x, COORD_W'(H_ACT - 1));
   assign lat_y = clamp_coord(avg_y, COORD_W'(V_ACT - 1));
`else
   logic unused_geom;
   assign unused_geom = ^{H_ACT, V_ACT};
   assign lat_x = avg_x;
   assign lat_y = avg_y;
`endif

   always_ff @(posedge video_clk or negedge rst_n) begin
      if (!rst_n) begin
         pix_x_q <= '0;
         pix_y_q <= '0;
         ena_q   <= 1'b0;
      end else if (vs_rise) begin
         pix_x_q <= lat_x;
         pix_y_q <= lat_y;
         ena_q   <= (state_q == TRACK);
      end
   end

   assign pix_x_out = pix_x_q;
   assign pix_y_out = pix_y_q;
   assign ena       = ena_q;

endmodule
